// File: rtl/fp32_minmax_reduce_pkg.sv
// Shared constants, state encoding and FP32 helpers for the min/max range reducer.
package fp32_minmax_reduce_pkg;

  localparam logic [31:0] FP32_QNAN     = 32'h7FC00000;
  localparam logic [7:0]  FP32_EXP_ALL1 = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic isNan(input logic [31:0] x);
    return (x[30:23] == FP32_EXP_ALL1) && (x[22:0] != 23'd0);
  endfunction

  // Maps an FP32 pattern to an unsigned key whose integer order matches
  // the float order, with -0 strictly below +0.
  function automatic logic [31:0] orderKey(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h80000000);
  endfunction

endpackage

// File: rtl/fp32_maxmin_unit.sv
// Combinational FP32 max/min of two non-NaN operands; on equal keys operand a wins.
module fp32_maxmin_unit
  import fp32_minmax_reduce_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] max_v,
  output logic [31:0] min_v
);

  logic [31:0] w_keyA;
  logic [31:0] w_keyB;

  assign w_keyA = orderKey(a);
  assign w_keyB = orderKey(b);

  assign max_v = (w_keyB > w_keyA) ? b : a;
  assign min_v = (w_keyB < w_keyA) ? b : a;

endmodule

// File: rtl/fp32_minmax_reduce.sv
// Streaming per-frame FP32 max/min/count/NaN tracker with a valid/ready result port.
module fp32_minmax_reduce
  import fp32_minmax_reduce_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_max,
  output logic [31:0]      m_min,
  output logic [CNT_W-1:0] m_count,
  output logic             m_nan_seen,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_stateNext;
  logic [31:0]      r_max;
  logic [31:0]      r_min;
  logic [CNT_W-1:0] r_count;
  logic             r_nanSeen;
  logic             r_haveVal;

  logic             w_accept;
  logic             w_isNan;
  logic             w_frameClear;
  logic [31:0]      w_unitMax;
  logic [31:0]      w_unitMin;
  logic [31:0]      w_unusedMinA;
  logic [31:0]      w_unusedMaxB;

  assign s_ready  = (r_state != DONE) && !clr;
  assign w_accept = s_valid && s_ready;
  assign w_isNan  = isNan(s_data);

  // A frame ends either by abort (clr outside DONE) or by the result handshake.
  assign w_frameClear = ((r_state != DONE) && clr) || ((r_state == DONE) && m_ready);

  fp32_maxmin_unit uMaxPath (
    .a     (r_max),
    .b     (s_data),
    .max_v (w_unitMax),
    .min_v (w_unusedMinA)
  );

  fp32_maxmin_unit uMinPath (
    .a     (r_min),
    .b     (s_data),
    .max_v (w_unusedMaxB),
    .min_v (w_unitMin)
  );

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE, ACCUM: begin
        if (clr)           w_stateNext = IDLE;
        else if (w_accept) w_stateNext = s_last ? DONE : ACCUM;
      end
      DONE: begin
        if (m_ready) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  // A NaN arriving before any ordered value parks the canonical qNaN in the
  // accumulators so an all-NaN frame reports it; the first real value overwrites it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_max     <= 32'd0;
      r_min     <= 32'd0;
      r_count   <= '0;
      r_nanSeen <= 1'b0;
      r_haveVal <= 1'b0;
    end else if (w_frameClear) begin
      r_count   <= '0;
      r_nanSeen <= 1'b0;
      r_haveVal <= 1'b0;
    end else if (w_accept) begin
      if (r_count != '1) r_count <= r_count + CNT_ONE;
      if (w_isNan) begin
        r_nanSeen <= 1'b1;
        if (!r_haveVal) begin
          r_max <= FP32_QNAN;
          r_min <= FP32_QNAN;
        end
      end else if (!r_haveVal) begin
        r_max     <= s_data;
        r_min     <= s_data;
        r_haveVal <= 1'b1;
      end else begin
        r_max <= w_unitMax;
        r_min <= w_unitMin;
      end
    end
  end

  assign m_valid    = (r_state == DONE);
  assign busy       = (r_state != IDLE);
  assign m_max      = r_max;
  assign m_min      = r_min;
  assign m_count    = r_count;
  assign m_nan_seen = r_nanSeen;

endmodule
